// File: rtl/spi_master_if.sv
// spi_master_if: transfer request/response and SPI pin bundle for spi_master
interface spi_master_if #(
  parameter int DATA_W = 8
);
  logic start, hold_cs, busy, done, sclk, mosi, miso, cs_n;
  logic [DATA_W-1:0] tx_data, rx_data;
  modport master (input start, hold_cs, tx_data, miso, output rx_data, busy, done, sclk, mosi, cs_n);
  modport slave (output start, hold_cs, tx_data, miso, input rx_data, busy, done, sclk, mosi, cs_n);
endinterface

// File: rtl/spi_master.sv
// spi_master: mode-0 SPI master with chip-select hold between words; SPI_MASTER_LOOPBACK_EN adds a mosi->sampler loopback port
module spi_master #(
  parameter int CLK_DIV = 4,
  parameter int DATA_W = 8
) (
  input logic clk,
  input logic rst,
`ifdef SPI_MASTER_LOOPBACK_EN
  input logic loopback,
`endif
  spi_master_if.master bus
);
  localparam int BW = $clog2(DATA_W + 1);
  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, RELEASE} state_t;
  state_t r_state, w_next;
  logic [7:0] r_cnt;
  logic [BW-1:0] r_bits;
  logic r_ph, r_hold, r_fin, r_done;
  logic [DATA_W-1:0] r_tsr, r_rsr, r_rx;
  logic w_wrap, w_last, w_acc, w_busy, w_sin;
  assign w_wrap = r_cnt == 8'(CLK_DIV - 1);
  assign w_busy = r_state inside {SETUP, SHIFT, RELEASE};
  assign w_acc = bus.start && !w_busy;
  assign w_last = r_state == SHIFT && w_wrap && r_ph && r_bits == BW'(DATA_W - 1);
`ifdef SPI_MASTER_LOOPBACK_EN
  assign w_sin = loopback ? r_tsr[DATA_W-1] : bus.miso;
`else
  assign w_sin = bus.miso;
`endif
  assign bus.busy = w_busy;
  assign bus.done = r_done;
  assign bus.rx_data = r_rx;
  assign bus.sclk = r_ph;
  assign bus.mosi = r_tsr[DATA_W-1];
  assign bus.cs_n = r_state inside {IDLE, RELEASE};
  // state register
  always_ff @(posedge clk) begin
    r_state <= rst ? IDLE : w_next;
  end
  // next state: a HOLD start skips SETUP since cs_n is already low
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = bus.start ? SETUP : IDLE;
      SETUP:   w_next = w_wrap ? SHIFT : SETUP;
      SHIFT:   w_next = w_last ? (r_hold ? HOLD : RELEASE) : SHIFT;
      HOLD:    w_next = bus.start ? SHIFT : (bus.hold_cs ? HOLD : RELEASE);
      RELEASE: w_next = w_wrap ? IDLE : RELEASE;
      default: w_next = IDLE;
    endcase
  end
  // divider, sclk phase, shift registers; done lags the final sclk fall by one cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
      r_bits <= '0;
      r_ph <= 1'b0;
      r_hold <= 1'b0;
      r_fin <= 1'b0;
      r_done <= 1'b0;
      r_tsr <= '0;
      r_rsr <= '0;
      r_rx <= '0;
    end else begin
      r_fin <= w_last;
      r_done <= r_fin;
      if (r_fin) r_rx <= r_rsr;
      r_cnt <= (w_busy && w_next == r_state && !w_wrap) ? r_cnt + 8'd1 : 8'd0;
      if (w_acc) begin
        r_tsr <= bus.tx_data;
        r_hold <= bus.hold_cs;
        r_bits <= '0;
        r_ph <= 1'b0;
      end else if (r_state == SHIFT && w_wrap) begin
        r_ph <= !r_ph;
        if (!r_ph) r_rsr <= DATA_W'({r_rsr, w_sin});
        else if (!w_last) begin
          r_bits <= r_bits + BW'(1);
          r_tsr <= r_tsr << 1;
        end
      end
    end
  end
endmodule

// File: tb/tb_spi_master.sv
// tb_spi_master: scoreboard bench for spi_master at CLK_DIV=4 and CLK_DIV=1
module tb_spi_master;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  int cyc = 0;
  int n_vec = 0;
  int n_err = 0;
  always @(posedge clk) cyc <= cyc + 1;
  spi_master_if #(.DATA_W(8)) b1 ();
  spi_master_if #(.DATA_W(8)) b2 ();
`ifdef SPI_MASTER_LOOPBACK_EN
  logic lb = 1'b0;
`endif
  spi_master #(.CLK_DIV(4), .DATA_W(8)) u1 (
    .clk(clk),
    .rst(rst),
`ifdef SPI_MASTER_LOOPBACK_EN
    .loopback(lb),
`endif
    .bus(b1)
  );
  spi_master #(.CLK_DIV(1), .DATA_W(8)) u2 (
    .clk(clk),
    .rst(rst),
`ifdef SPI_MASTER_LOOPBACK_EN
    .loopback(1'b0),
`endif
    .bus(b2)
  );
  logic [7:0] s1 = '0, s2 = '0;
  logic [2:0] k1 = '0, k2 = '0;
  assign b1.miso = s1[3'd7 - k1];
  assign b2.miso = s2[3'd7 - k2];
  logic [31:0] q_rx1[$], q_cyc1[$], q_tx1[$], q_rx2[$], q_cyc2[$];
  logic p_sclk1 = 1'b0, p_cs1 = 1'b1, p_sclk2 = 1'b0, p_cs2 = 1'b1;
  logic [7:0] m1 = '0;
  int mc1 = 0, cs_rise1 = 0, cs_rises1 = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  always @(negedge clk) begin
    if (b1.done) begin
      if (q_rx1.size() == 0) chk("done1_unexpected", 1, 0);
      else begin
        chk("rx1", b1.rx_data, q_rx1.pop_front());
        chk("done1_cyc", cyc, q_cyc1.pop_front());
      end
    end
    if (b1.cs_n && !p_cs1) begin
      cs_rise1 = cyc;
      cs_rises1++;
      k1 = '0;
      mc1 = 0;
    end else begin
      if (b1.sclk && !p_sclk1) begin
        m1 = {m1[6:0], b1.mosi};
        mc1++;
        if (mc1 == 8) begin
          mc1 = 0;
          if (q_tx1.size() == 0) chk("mosi1_unexpected", 1, 0);
          else chk("mosi1", m1, q_tx1.pop_front());
        end
      end
      if (!b1.sclk && p_sclk1) k1 = k1 + 3'd1;
    end
    p_sclk1 = b1.sclk;
    p_cs1 = b1.cs_n;
  end
  always @(negedge clk) begin
    if (b2.done) begin
      if (q_rx2.size() == 0) chk("done2_unexpected", 1, 0);
      else begin
        chk("rx2", b2.rx_data, q_rx2.pop_front());
        chk("done2_cyc", cyc, q_cyc2.pop_front());
      end
    end
    if (b2.cs_n && !p_cs2) k2 = '0;
    else if (!b2.sclk && p_sclk2) k2 = k2 + 3'd1;
    p_sclk2 = b2.sclk;
    p_cs2 = b2.cs_n;
  end
  task automatic go1(input logic [7:0] tx, input logic hold, input logic [7:0] sw, input int lat, input bit exp, output int a);
    s1 = sw;
    b1.tx_data = tx;
    b1.hold_cs = hold;
    b1.start = 1'b1;
    @(negedge clk);
    a = cyc;
    b1.start = 1'b0;
    chk("busy1_acc", b1.busy, 1);
    chk("csn1_acc", b1.cs_n, 0);
    if (exp) begin
      q_tx1.push_back(32'(tx));
      q_rx1.push_back(32'(sw));
      q_cyc1.push_back(32'(a + lat));
    end
  endtask
  task automatic wait_done(input bit d, input string nm);
    bit seen = 1'b0;
    for (int i = 0; i < 300 && !seen; i++) begin
      @(negedge clk);
      seen = d ? b2.done : b1.done;
    end
    chk(nm, seen, 1);
  endtask
  task automatic wait_idle1(output int t);
    t = -1;
    for (int i = 0; i < 100 && t < 0; i++) begin
      @(negedge clk);
      if (!b1.busy) t = cyc;
    end
    chk("idle1_seen", t >= 0, 1);
  endtask
  int a, a2, t, r0;
  initial begin
    b1.start = 1'b0;
    b1.hold_cs = 1'b0;
    b1.tx_data = '0;
    b2.start = 1'b0;
    b2.hold_cs = 1'b0;
    b2.tx_data = '0;
    repeat (3) @(negedge clk);
    chk("rst_csn", b1.cs_n, 1);
    chk("rst_sclk", b1.sclk, 0);
    chk("rst_mosi", b1.mosi, 0);
    chk("rst_busy", b1.busy, 0);
    chk("rst_done", b1.done, 0);
    chk("rst_rx", b1.rx_data, 0);
    chk("rst2_csn", b2.cs_n, 1);
    chk("rst2_busy", b2.busy, 0);
    rst = 1'b0;
    @(negedge clk);
    go1(8'h77, 1'b0, 8'h55, 0, 1'b0, a);
    repeat (30) @(negedge clk);
    chk("abort_busy_pre", b1.busy, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_csn", b1.cs_n, 1);
    chk("abort_sclk", b1.sclk, 0);
    chk("abort_busy", b1.busy, 0);
    chk("abort_done", b1.done, 0);
    chk("abort_rx", b1.rx_data, 0);
    repeat (100) @(negedge clk);
    go1(8'hA5, 1'b0, 8'h3C, 69, 1'b1, a);
    wait_done(1'b0, "a5_done_seen");
    chk("a5_busy_at_done", b1.busy, 1);
    wait_idle1(t);
    chk("a5_csn_rise", cs_rise1, a + 68);
    chk("a5_release_len", t - cs_rise1, 4);
    r0 = cs_rises1;
    go1(8'h12, 1'b1, 8'hC3, 69, 1'b1, a);
    wait_done(1'b0, "hold1_done_seen");
    chk("hold_busy", b1.busy, 0);
    chk("hold_csn", b1.cs_n, 0);
    b1.hold_cs = 1'b0;
    go1(8'h34, 1'b0, 8'h96, 65, 1'b1, a2);
    wait_done(1'b0, "hold2_done_seen");
    chk("hold_cs_rises", cs_rises1, r0 + 1);
    chk("hold_csn_rise", cs_rise1, a2 + 64);
    wait_idle1(t);
    go1(8'h81, 1'b0, 8'hE7, 69, 1'b1, a);
    b1.start = 1'b1;
    wait_done(1'b0, "pulse_done_seen");
    b1.start = 1'b0;
    wait_idle1(t);
    repeat (100) @(negedge clk);
    chk("pulse_idle_busy", b1.busy, 0);
    s2 = 8'h6B;
    b2.tx_data = 8'hFF;
    b2.start = 1'b1;
    @(negedge clk);
    a = cyc;
    b2.start = 1'b0;
    q_rx2.push_back(32'h6B);
    q_cyc2.push_back(32'(a + 18));
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      chk("div1_sclk", b2.sclk, 32'(i % 2 == 0));
    end
    wait_done(1'b1, "div1_done_seen");
`ifdef SPI_MASTER_LOOPBACK_EN
    repeat (10) @(negedge clk);
    lb = 1'b1;
    go1(8'h5A, 1'b0, 8'h00, 69, 1'b1, a);
    q_rx1[q_rx1.size()-1] = 32'h5A;
    wait_done(1'b0, "lb_done_seen");
    wait_idle1(t);
    lb = 1'b0;
`endif
    repeat (20) @(negedge clk);
    chk("q_rx1_empty", q_rx1.size(), 0);
    chk("q_tx1_empty", q_tx1.size(), 0);
    chk("q_rx2_empty", q_rx2.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/spi_master.md
SPI_MASTER -- requirements
Module: spi_master

Interface
REQ-001 Parameter: CLK_DIV, default 4, SCLK half-period in clk cycles; legal range 1..255.
REQ-002 Parameter: DATA_W, default 8, bits per transfer; legal range 1..32.
REQ-003 Port: clk  in  1  system clock from the on-chip HF oscillator; sole clock, all logic on posedge.
REQ-004 Port: rst  in  1  synchronous, active-high reset.
REQ-005 Port: start  in  1  request a transfer; sampled only when busy=0.
REQ-006 Port: hold_cs  in  1  keep cs_n asserted after this transfer; sampled with start.
REQ-007 Port: tx_data  in  DATA_W  word to send, MSB first; sampled with start.
REQ-008 Port: rx_data  out  DATA_W  last received word; updated only in the cycle done=1.
REQ-009 Port: busy  out  1  high from the cycle after an accepted start until ready for the next start.
REQ-010 Port: done  out  1  single-cycle pulse when a transfer completes.
REQ-011 Port: sclk  out  1  SPI clock, mode 0 (CPOL=0, CPHA=0).
REQ-012 Port: mosi  out  1  SPI data out.
REQ-013 Port: miso  in  1  SPI data in; single-flop sampled, no synchronizer.
REQ-014 Port: cs_n  out  1  active-low chip select.

Function
REQ-015 The block SHALL implement states IDLE, SETUP, SHIFT, HOLD and RELEASE.
REQ-016 IDLE: cs_n=1, sclk=0, busy=0; start=1 SHALL latch tx_data and hold_cs and move to SETUP, with cs_n=0 and busy=1 from the next cycle.
REQ-017 SETUP SHALL last CLK_DIV cycles with mosi=tx_data MSB and sclk=0, then enter SHIFT.
REQ-018 SHIFT SHALL produce DATA_W SCLK periods, each CLK_DIV cycles low then CLK_DIV cycles high.
REQ-019 miso SHALL be sampled into the receive shift register on the clk edge that drives sclk 0->1; mosi SHALL advance to the next bit on sclk 1->0.
REQ-020 After the last high phase, sclk SHALL return to 0, rx_data SHALL load the received word and done SHALL pulse for 1 cycle, exactly 1+(2*DATA_W+1)*CLK_DIV cycles after the accepting edge.
REQ-021 If latched hold_cs=1, the block SHALL enter HOLD: cs_n=0, sclk=0, busy=0; start SHALL begin a new transfer directly in SHIFT (no SETUP), with cs_n held low.
REQ-022 In HOLD, start=0 with hold_cs=0 for 1 cycle SHALL move the block to RELEASE (deassert request).
REQ-023 If latched hold_cs=0, the block SHALL enter RELEASE: cs_n=1, busy=1 for CLK_DIV cycles, then IDLE.
REQ-024 start while busy=1 SHALL be ignored; no queuing.
REQ-025 The internal divider counter SHALL be 8 bits and wrap only under state control; the bit counter SHALL be sized ceil(log2(DATA_W+1)).
REQ-026 done and an accepted start in the same cycle (HOLD path) SHALL be allowed; rx_data SHALL not change until the next done.

Reset
REQ-027 rst=1 SHALL force IDLE on the next edge regardless of state: cs_n=1, sclk=0, mosi=0, busy=0, done=0, rx_data=0.
REQ-028 Reset mid-transfer SHALL abort with no done pulse and no rx_data update.

Configuration
REQ-029 Macro SPI_MASTER_LOOPBACK_EN: when defined, an input port loopback (1 bit) SHALL exist and, when high, route mosi internally to the receive sampler instead of miso; when undefined, the port SHALL be absent and miso SHALL always be used.

Verification
REQ-030 CLK_DIV=4, DATA_W=8, start with tx_data=0xA5, hold_cs=0, miso driven by slave model returning 0x3C -> mosi bits 1,0,1,0,0,1,0,1 on rising sclk, done at cycle 69 after start, rx_data=0x3C, cs_n high 4 cycles before busy=0.
REQ-031 Two transfers 0x12 (hold_cs=1) then 0x34 (hold_cs=0) -> cs_n stays low across both, second has no SETUP, rx_data matches slave per word.
REQ-032 start pulsed every cycle during a transfer -> exactly one transfer, one done.
REQ-033 rst asserted at SCLK period 4 of a transfer -> next cycle cs_n=1, sclk=0, busy=0, no done, rx_data unchanged at 0.
REQ-034 CLK_DIV=1, tx_data=0xFF -> sclk toggles every clk, done at cycle 18, rx_data matches.
REQ-035 With SPI_MASTER_LOOPBACK_EN and loopback=1, tx_data=0x5A, miso tied 0 -> rx_data=0x5A.
